mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-cache access sequencer
// Holds the pipeline while one load/store is outstanding on the cache; every output except mem_stall comes from a flop.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        halt_in,
  input  logic        flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mwb_wen,
  output logic        halt_out,
  output logic        timeout_err,
  output logic [31:0] access_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, DONE, HALTED} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   count_q, count_d;
  logic          is_write_q, is_write_d;
  logic          halt_pend_q, halt_pend_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          stall_q, stall_d;
  logic          mwb_q, mwb_d;
  logic          halted_q, halted_d;
  logic          mem_op;
  logic [CW-1:0] wait_inc;

  assign mem_op   = valid & ~flush & (mem_read | mem_write);
  assign wait_inc = wait_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_d      = load_q;
    count_d     = count_q;
    is_write_d  = is_write_q;
    halt_pend_d = halt_pend_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          addr_d      = addr;
          wdata_d     = store_data;
          is_write_d  = mem_write;
          halt_pend_d = halt_in;
          wait_d      = '0;
          state_d     = REQ;
        end else if (valid && !flush && halt_in) begin
          state_d = HALTED;
        end
      end
      REQ: begin
        // A hit on the same cycle the counter expires still wins over the timeout.
        if (dhit) begin
          if (!is_write_q) load_d = dmemload;
          count_d = count_q + 32'd1;
          state_d = DONE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TMO) begin
            tmo_d = 1'b1;
            if (!is_write_q) load_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = halt_pend_q ? HALTED : IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Registered copies of the state decode, so the strobes never glitch.
  always_comb begin
    ren_d    = (state_d == REQ) && !is_write_d;
    wen_d    = (state_d == REQ) && is_write_d;
    stall_d  = (state_d == REQ) || (state_d == HALTED);
    mwb_d    = (state_d == IDLE) || (state_d == DONE);
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_q      <= '0;
      count_q     <= '0;
      is_write_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      tmo_q       <= 1'b0;
      wait_q      <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      stall_q     <= 1'b0;
      mwb_q       <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_q      <= load_d;
      count_q     <= count_d;
      is_write_q  <= is_write_d;
      halt_pend_q <= halt_pend_d;
      tmo_q       <= tmo_d;
      wait_q      <= wait_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      stall_q     <= stall_d;
      mwb_q       <= mwb_d;
      halted_q    <= halted_d;
    end
  end

  assign dmemREN      = ren_q;
  assign dmemWEN      = wen_q;
  assign dmemaddr     = addr_q;
  assign dmemstore    = wdata_q;
  assign load_data    = load_q;
  assign mem_stall    = stall_q | ((state_q == IDLE) & mem_op);
  assign mwb_wen      = mwb_q;
  assign halt_out     = halted_q;
  assign timeout_err  = tmo_q;
  assign access_count = count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST, valid, mem_read, mem_write, halt_in, flush, dhit;
  logic [31:0] addr, store_data, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, mwb_wen, halt_out, timeout_err;
  logic [31:0] dmemaddr, dmemstore, load_data, access_count;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .store_data(store_data), .halt_in(halt_in), .flush(flush), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .load_data(load_data), .mem_stall(mem_stall), .mwb_wen(mwb_wen),
    .halt_out(halt_out), .timeout_err(timeout_err), .access_count(access_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] sd;
    int          cycles;
    logic [31:0] load;
    logic [31:0] count;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [31:0] m_count = 0;
  logic [31:0] m_load = 0;
  bit          m_tmo = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid = 0; mem_read = 0; mem_write = 0; halt_in = 0; flush = 0; dhit = 0;
    addr = 0; store_data = 0; dmemload = 0;
  endtask

  task automatic junk_inputs();
    valid = 1'($urandom); flush = 1'($urandom); mem_read = 1'($urandom);
    mem_write = 1'($urandom); halt_in = 1'($urandom);
    addr = $urandom; store_data = $urandom;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; idle_inputs();
    @(posedge CLK); #1;
    chk("rst_ren", dmemREN, 0);
    chk("rst_wen", dmemWEN, 0);
    chk("rst_addr", dmemaddr, 0);
    chk("rst_store", dmemstore, 0);
    chk("rst_load", load_data, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_mwb", mwb_wen, 1);
    chk("rst_halt", halt_out, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_count", access_count, 0);
    @(negedge CLK);
    RST = 0;
    m_count = 0; m_load = 0; m_tmo = 0;
  endtask

  // d = REQ cycle on which dhit arrives; d > TO means the cache never answers.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] sd,
                       input int d, input logic [31:0] rdata, input bit hlt);
    exp_t e;
    bit   hit;
    int   n;
    @(negedge CLK);
    valid = 1; flush = 0; mem_read = rd; mem_write = wr; addr = a; store_data = sd;
    halt_in = hlt; dhit = 1'($urandom); dmemload = $urandom;
    hit = (d <= TO);
    n = hit ? d : TO;
    if (hit) begin
      m_count = m_count + 1;
      if (!wr) m_load = rdata;
    end else begin
      m_tmo = 1;
      if (!wr) m_load = 0;
    end
    e.wr = wr; e.addr = a; e.sd = sd; e.cycles = n;
    e.load = m_load; e.count = m_count; e.tmo = m_tmo;
    sb.push_back(e);
    #1 chk("capture_stall", mem_stall, 1);
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      junk_inputs();
      dhit = (k == d);
      dmemload = (k == d) ? rdata : $urandom;
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    idle_inputs();
    dhit = 1'($urandom);
    dmemload = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      valid = 1; flush = 1; mem_read = 1'($urandom); mem_write = 1'($urandom);
    end else begin
      valid = 0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    end
    addr = $urandom;
    #1 chk("idle_no_stall", mem_stall, 0);
  endtask

  // Monitor: follows each strobe burst and scores it against the queue when it ends.
  initial begin : monitor
    bit          in_req;
    int          req_cnt;
    bit          cap_wr;
    logic [31:0] cap_addr, cap_sd;
    exp_t        e;
    in_req = 0; req_cnt = 0; cap_wr = 0; cap_addr = 0; cap_sd = 0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        in_req = 0;
        continue;
      end
      if (dmemREN || dmemWEN) begin
        if (!in_req) begin
          in_req = 1; req_cnt = 1;
          cap_wr = dmemWEN; cap_addr = dmemaddr; cap_sd = dmemstore;
        end else begin
          req_cnt++;
          chk("req_addr_stable", dmemaddr, cap_addr);
          chk("req_store_stable", dmemstore, cap_sd);
          chk("req_kind_stable", dmemWEN, cap_wr);
        end
        chk("req_one_strobe", dmemREN & dmemWEN, 0);
        chk("req_stall", mem_stall, 1);
        chk("req_mwb", mwb_wen, 0);
        if (req_cnt > TO + 2) begin
          total++; bad++;
          $display("FAIL req_bound: strobe held %0d cycles, limit %0d", req_cnt, TO);
          in_req = 0;
        end
      end else if (in_req) begin
        in_req = 0;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_access: addr %h with no request issued", cap_addr);
        end else begin
          e = sb.pop_front();
          chk("kind", cap_wr, e.wr);
          chk("addr", cap_addr, e.addr);
          chk("store", cap_sd, e.sd);
          chk("req_cycles", req_cnt, e.cycles);
          chk("load_data", load_data, e.load);
          chk("access_count", access_count, e.count);
          chk("timeout_err", timeout_err, e.tmo);
          chk("done_stall", mem_stall, 0);
          chk("done_mwb", mwb_wen, 1);
        end
      end
    end
  end

  initial begin : driver
    bit [1:0] k;
    int       wait_cnt;
    RST = 1;
    idle_inputs();
    repeat (2) @(negedge CLK);
    do_reset();

    do_op(1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
    do_op(0, 1, 32'h200, 32'h12345678, 1, 32'h0, 0);
    do_op(1, 1, 32'h204, 32'hA5A5A5A5, 2, 32'h11111111, 0);
    do_op(1, 0, 32'h300, 32'h0, TO, 32'hCAFEF00D, 0);

    @(negedge CLK);
    idle_inputs();
    valid = 1; flush = 1; mem_read = 1; addr = 32'h500;
    #1 chk("flushed_load_stall", mem_stall, 0);
    idle_cycle();

    do_op(1, 0, 32'h400, 32'h0, TO + 1, 32'h55, 0);

    repeat (150) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      k = 2'($urandom_range(0, 2));
      do_op(k != 2'd1, k != 2'd0, $urandom, $urandom, $urandom_range(1, TO + 1), $urandom, 0);
    end

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(negedge CLK);
      wait_cnt++;
    end
    chk("sb_drained", sb.size(), 0);

    // Reset in the middle of a request: nothing may be retried afterwards.
    @(negedge CLK);
    idle_inputs();
    valid = 1; mem_read = 1; addr = 32'h600;
    repeat (2) begin
      @(negedge CLK);
      junk_inputs();
      dhit = 0;
    end
    do_reset();
    repeat (3) idle_cycle();
    chk("no_retry_count", access_count, 0);

    do_op(1, 0, 32'h700, 32'h0, 2, 32'h0BADF00D, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("halt_after_op", halt_out, 1);
      chk("halt_stall", mem_stall, 1);
      chk("halt_mwb", mwb_wen, 0);
      chk("halt_no_strobe", dmemREN | dmemWEN, 0);
      @(negedge CLK);
      valid = 1; mem_read = 1; dhit = 1'($urandom); addr = $urandom;
    end

    do_reset();
    @(negedge CLK);
    idle_inputs();
    valid = 1; halt_in = 1;
    #1 chk("halt_cycle_stall", mem_stall, 0);
    @(posedge CLK); #1;
    chk("halt_out", halt_out, 1);
    chk("halted_stall", mem_stall, 1);
    chk("halted_count", access_count, 0);
    @(negedge CLK);
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1 chk("halt_sticky", halt_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
